// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared defaults and test word constants for the handshake slave FIFO
package hs_pkg;
  localparam int DEF_DATA_W    = 3;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_FRAME_LEN = 3;
  localparam int CNT_W         = 8;

  localparam logic [2:0] W0 = 3'b111;
  localparam logic [2:0] W1 = 3'b101;
  localparam logic [2:0] W2 = 3'b110;
endpackage

// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - show-ahead FIFO with registered ready and count-derived full/empty
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              full,
  output logic              empty,
  output logic              push
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              pop;

  assign push    = valid && ready;
  assign pop     = m_valid && m_ready;
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign m_valid = !empty;
  assign m_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (!push && pop)
      count_next = count - CNT_ONE;
  end

  // ready looks ahead at count_next so it never depends on this cycle's valid/m_ready
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      ready <= (count_next < CNT_MAX);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= data;
  end
endmodule

// File: rtl/hs_slave_fifo.sv
// rtl/hs_slave_fifo.sv - handshake slave: buffers words and tracks word and frame counts
module hs_slave_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              frame_done
);
  localparam int FI_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FI_W-1:0]  FI_ONE     = FI_W'(1);
  localparam logic [FI_W-1:0]  FRAME_LAST = FI_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_INC    = CNT_W'(1);

  logic            push;
  logic [FI_W-1:0] frame_idx;

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .valid   (valid),
    .data    (data),
    .ready   (ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .full    (full),
    .empty   (empty),
    .push    (push)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      word_cnt   <= '0;
      frame_cnt  <= '0;
      frame_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (push) begin
        word_cnt <= word_cnt + CNT_INC;
        if (frame_idx == FRAME_LAST) begin
          frame_idx  <= '0;
          frame_cnt  <= frame_cnt + CNT_INC;
          frame_done <= 1'b1;
        end else begin
          frame_idx <= frame_idx + FI_ONE;
        end
      end
    end
  end
endmodule
